// File: rtl/pmod_pkg.sv
// Shared types and constants for the PMOD push-button reader.
// Holds the debounce state encoding and the helper that converts a debounce time into clock cycles.
package pmod_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    DOWN_WAIT = 2'd1,
    DOWN      = 2'd2,
    UP_WAIT   = 2'd3
  } db_state_e;

  localparam int unsigned CLK_HZ = 32'd12_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned clk_hz);
    return ms * (clk_hz / 32'd1000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button reader: two-flop synchronizer, then a debounce FSM that reports
// a one-cycle press pulse and a debounced held level, both registered.
module btn_debounce
  import pmod_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic press,
  output logic held
);

  localparam int unsigned CNT_BITS = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] ONE   = CNT_BITS'(1);

  logic                sync_meta_q;
  logic                sync_n_q;
  db_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] cnt_inc_s;
  logic                press_q, press_d;
  logic                held_q, held_d;

  assign cnt_inc_s = cnt_q + ONE;

  // Next-state, stability-count and output decode for the debounce FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UP: begin
        if (!sync_n_q) begin
          state_d = DOWN_WAIT;
          cnt_d   = ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      DOWN_WAIT: begin
        if (sync_n_q) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_inc_s == LIMIT) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      DOWN: begin
        if (sync_n_q) begin
          state_d = UP_WAIT;
          cnt_d   = ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      UP_WAIT: begin
        if (!sync_n_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_inc_s == LIMIT) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
    // Only the DOWN_WAIT -> DOWN transition is a press; release is silent.
    press_d = (state_q == DOWN_WAIT) && (state_d == DOWN);
    held_d  = (state_d == DOWN) || (state_d == UP_WAIT);
  end

  // Synchronizer, FSM state, stability counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q <= 1'b1;
      sync_n_q    <= 1'b1;
      state_q     <= UP;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync_meta_q <= pin_n;
      sync_n_q    <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      held_q      <= held_d;
    end
  end

  assign press = press_q;
  assign held  = held_q;

endmodule

// File: rtl/pmod_button_counter.sv
// PMOD button reader: debounces every button and keeps an up/down counter
// (button 0 up, button 1 down) that is shown directly on the LEDs.
module pmod_button_counter
  import pmod_pkg::*;
#(
  parameter int unsigned N_BTN           = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(32'd10, CLK_HZ),
  parameter int unsigned CNT_W           = 32'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pmod,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] held,
  output logic [CNT_W-1:0] led
);

  logic [CNT_W-1:0] count_q, count_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin_n(pmod[i]),
      .press(press[i]),
      .held (held[i])
    );
  end

  // Up/down step; simultaneous up and down presses cancel
  always_comb begin
    count_d = count_q;
    case ({press[0], press[1]})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign led = count_q;

endmodule

// File: tb/tb_pmod_button_counter.sv
// Scoreboard bench for pmod_button_counter with a short debounce window.
module tb_pmod_button_counter;

  localparam int unsigned N_BTN = 2;
  localparam int unsigned DB    = 4;
  localparam int unsigned CW    = 3;

  typedef struct {
    int         cyc;
    logic [1:0] mask;
    logic [2:0] led;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    pmod = 2'b11;
  logic [1:0]    press;
  logic [1:0]    held;
  logic [2:0]    led;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e;
  logic       led_pend = 1'b0;
  logic [2:0] led_exp;
  int n, r, m;

  pmod_button_counter #(
    .N_BTN(N_BTN),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pmod (pmod),
    .press(press),
    .held (held),
    .led  (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // pmod changes at the current negedge (cycle n); press is due after edge n+2+DB
  task automatic push_press(input logic [1:0] mask, input logic [2:0] led_after);
    exp_q.push_back('{cyc + 2 + DB, mask, led_after});
  endtask

  task automatic press_release(input logic [1:0] mask, input int hold, input logic [2:0] led_after);
    pmod = pmod & ~mask;
    push_press(mask, led_after);
    repeat (hold) tick();
    pmod = 2'b11;
    repeat (8) tick();
  endtask

  // Monitor: every press pulse pops one expected event, then the LED is checked a cycle later
  always @(negedge clk) begin
    if (led_pend) begin
      check("led_after_press", led, led_exp);
      led_pend = 1'b0;
    end
    if (!rst && press !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_press", press, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("press_cycle", cyc, e.cyc);
        check("press_mask", press, e.mask);
        led_exp  = e.led;
        led_pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    pmod = 2'b11;
    repeat (3) begin
      tick();
      check("reset_led", led, 3'd0);
      check("reset_press", press, 2'b00);
      check("reset_held", held, 2'b00);
    end
    rst = 1'b0;

    // Single-cycle glitches on button 0
    pmod[0] = 1'b0; tick();
    pmod[0] = 1'b1; tick();
    pmod[0] = 1'b0; tick();
    pmod[0] = 1'b1;
    repeat (10) begin
      tick();
      check("bounce_held", held, 2'b00);
      check("bounce_led", led, 3'd0);
    end

    // Clean press held for 20 cycles
    n = cyc;
    pmod[0] = 1'b0;
    push_press(2'b01, 3'd1);
    repeat (20) begin
      tick();
      check("clean_held_on", held[0], (cyc >= n + 2 + DB) ? 1'b1 : 1'b0);
    end
    r = cyc;
    pmod = 2'b11;
    repeat (8) begin
      tick();
      check("clean_held_off", held[0], (cyc < r + 2 + DB) ? 1'b1 : 1'b0);
    end

    // Seven more up presses wrap 7 -> 0
    for (int k = 2; k <= 8; k++) press_release(2'b01, 8, 3'(k % 8));
    check("wrap_up_led", led, 3'd0);
    press_release(2'b10, 8, 3'd7);
    check("wrap_down_led", led, 3'd7);

    // Count up to 3, then press both together
    for (int k = 0; k < 4; k++) press_release(2'b01, 8, 3'(k));
    press_release(2'b11, 8, 3'd3);
    check("simul_led", led, 3'd3);

    // Reset while button 0 is held
    pmod[0] = 1'b0;
    push_press(2'b01, 3'd4);
    repeat (9) tick();
    check("pre_reset_held", held[0], 1'b1);
    rst = 1'b1;
    tick();
    check("midreset_held", held, 2'b00);
    check("midreset_led", led, 3'd0);
    check("midreset_press", press, 2'b00);
    rst = 1'b0;
    m = cyc;
    push_press(2'b01, 3'd1);
    repeat (12) tick();
    pmod = 2'b11;
    repeat (10) tick();
    check("post_reset_led", led, 3'd1);
    check("pending_presses", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
